mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the eLC-3 datapath's memory port.
- Accepts a request (address, write data, read/write) from the CPU control unit.
- Services the request either against the external async SRAM with configurable wait states or against memory-mapped I/O (switches and hex display).
- Returns read data plus a level Ready signal, which the control FSM polls as its R condition.

Parameters:
- WAIT_STATES, 2: cycles the SRAM strobes stay asserted per access; minimum 1.
- MMIO_ADDR, 16'hFFFF: I/O address. A read returns Switches; a write loads Hex_Out.
- SRAM_AW, 20: SRAM address width.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  access request (MIO_EN level from the control unit).
- WE  in  1  1 = write, 0 = read; sampled when the request is accepted.
- Address  in  16  word address (MAR).
- Data_In  in  16  write data (MDR).
- Data_Out  out  16  read data to the datapath In port.
- Ready  out  1  access complete; held until Req drops.
- Busy  out  1  high in any state other than IDLE.
- Switches  in  16  board switch inputs.
- Hex_Out  out  16  hex display register.
- SRAM_Addr  out  SRAM_AW  SRAM address.
- SRAM_WData  out  16  SRAM write data.
- SRAM_RData  in  16  SRAM read data.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset (Reset low, asynchronous):
  - State goes to IDLE.
  - Data_Out, Hex_Out, SRAM_Addr and SRAM_WData clear to 0.
  - Ready and Busy clear to 0.
  - All five SRAM strobes go to 1 (inactive).
  - Reset during an access aborts it immediately; no partial write is reported as complete.
- States: IDLE, ACCESS, MMIO, DONE.
- IDLE:
  - When Req=1, latch Address, WE and Data_In.
  - If Address==MMIO_ADDR, go to MMIO; otherwise load the wait counter with WAIT_STATES-1 and go to ACCESS.
  - Changes to Address, WE or Data_In after acceptance are ignored.
- ACCESS, read:
  - CE_N=0, OE_N=0, WE_N=1, UB_N=0, LB_N=0.
  - SRAM_Addr = zero-extended latched address.
  - When the counter reaches 0, capture SRAM_RData into Data_Out and go to DONE.
  - Otherwise decrement the counter.
- ACCESS, write:
  - CE_N=0, WE_N=0, OE_N=1, UB_N=0, LB_N=0.
  - SRAM_WData = latched data for the whole access and through DONE.
  - Go to DONE when the counter reaches 0.
- MMIO:
  - Lasts one cycle; SRAM strobes stay inactive.
  - Read: Data_Out <= Switches, sampled in this cycle.
  - Write: Hex_Out <= latched data.
  - Next state is DONE.
- DONE:
  - Ready=1 and all strobes inactive.
  - Stay in DONE while Req=1; go to IDLE when Req=0.
  - Ready drops on entry to IDLE.
  - This ensures one continuous MIO_EN assertion produces exactly one access.
- Latency from Req accepted in IDLE to Ready high:
  - SRAM access: WAIT_STATES+1 cycles.
  - MMIO access: 2 cycles.
- Data_Out holds the last read value and is not altered by writes.
- Hex_Out changes only on MMIO writes.
- Req dropping mid-access does not abort it. The access completes, passes through DONE for one cycle with Ready=1, then returns to IDLE.
- Req=1 while Reset is low is ignored.
- Busy = (state != IDLE).

Decomposition:
- Shared package elc3_mem_pkg holds:
  - mem_state_t enum {IDLE, ACCESS, MMIO, DONE}.
  - MMIO_ADDR default constant.
  - STROBE_OFF constant (5'b11111).
- Wait counter width is $clog2(WAIT_STATES+1).
- No sub-module: the FSM, counter and MMIO register are implemented in one module.

Test Plan:
- SRAM write then read: write Data_In=16'h1234 to 16'h0040, then read 16'h0040 with WAIT_STATES=2.
  - SRAM_WE_N is low for exactly 2 cycles with SRAM_Addr=20'h00040.
  - Ready rises 3 cycles after acceptance.
  - The read returns Data_Out=16'h1234 from the SRAM model.
- MMIO read: Switches=16'h00A5, read 16'hFFFF.
  - No SRAM strobe ever goes low.
  - Data_Out=16'h00A5 and Ready rises 2 cycles after acceptance.
- MMIO write: write 16'hBEEF to 16'hFFFF.
  - Hex_Out=16'hBEEF.
  - A following SRAM read of 16'hFFFE leaves Hex_Out unchanged.
- Held request: hold Req=1 for 10 cycles after Ready.
  - Exactly one SRAM access occurs; Ready stays 1 and Busy stays 1.
  - After Req drops, Ready=0 and Busy=0 on the next cycle.
- Reset mid-write: pull Reset low during ACCESS cycle 1.
  - All strobes read 1 in the same cycle, state is IDLE, Ready=0, Data_Out=0, Hex_Out=0.
  - After reset release with Req=1, a fresh access starts.
- Latch check: change Address from 16'h0010 to 16'h0020 during an ACCESS read.
  - SRAM_Addr stays 20'h00010 for the whole access.

Source files
------------

// File: rtl/elc3_mem_pkg.sv
// elc3_mem_pkg: shared types and constants for the eLC-3 memory responder.
package elc3_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, MMIO, DONE} mem_state_t;
    localparam logic [15:0] MMIO_ADDR_DEF = 16'hFFFF;
    localparam logic [4:0] STROBE_OFF = 5'b11111;
endpackage

// File: rtl/mem_responder.sv
// mem_responder: services CPU memory requests against async SRAM (with wait states) or MMIO.
module mem_responder
    import elc3_mem_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter logic [15:0] MMIO_ADDR = MMIO_ADDR_DEF,
    parameter int SRAM_AW = 20
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Req,
    input  logic               WE,
    input  logic [15:0]        Address,
    input  logic [15:0]        Data_In,
    output logic [15:0]        Data_Out,
    output logic               Ready,
    output logic               Busy,
    input  logic [15:0]        Switches,
    output logic [15:0]        Hex_Out,
    output logic [SRAM_AW-1:0] SRAM_Addr,
    output logic [15:0]        SRAM_WData,
    input  logic [15:0]        SRAM_RData,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);
    localparam int CW = $clog2(WAIT_STATES + 1);

    mem_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   addr_q, addr_d, wdata_q, wdata_d, dout_q, dout_d, hex_q, hex_d;
    logic          we_q, we_d;
    logic [4:0]    strobe;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            hex_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            hex_q   <= hex_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        hex_d   = hex_q;
        we_d    = we_q;
        case (state_q)
            IDLE: if (Req) begin
                addr_d  = Address;
                wdata_d = Data_In;
                we_d    = WE;
                cnt_d   = CW'(WAIT_STATES - 1);
                state_d = (Address == MMIO_ADDR) ? MMIO : ACCESS;
            end
            ACCESS: begin
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
                dout_d  = (cnt_q == '0 && !we_q) ? SRAM_RData : dout_q;
                state_d = (cnt_q == '0) ? DONE : ACCESS;
            end
            MMIO: begin
                hex_d   = we_q ? wdata_q : hex_q;
                dout_d  = we_q ? dout_q : Switches;
                state_d = DONE;
            end
            default: state_d = Req ? DONE : IDLE;
        endcase
    end

    // Strobe order {CE, OE, WE, UB, LB}; only ACCESS drives the SRAM
    always_comb begin
        strobe = (state_q != ACCESS) ? STROBE_OFF : (we_q ? 5'b01000 : 5'b00100);
        {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} = strobe;
        Ready      = (state_q == DONE);
        Busy       = (state_q != IDLE);
        Data_Out   = dout_q;
        Hex_Out    = hex_q;
        SRAM_Addr  = SRAM_AW'(addr_q);
        SRAM_WData = wdata_q;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven, hand-sequenced and randomized checks of mem_responder.
module tb_mem_responder;
    localparam int WS = 2;

    logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0;
    logic [15:0] address = '0, data_in = '0, switches = '0;
    logic [15:0] data_out, hex_out, sram_wdata, sram_rdata;
    logic [19:0] sram_addr;
    logic        ready, busy, ce_n, oe_n, we_n, ub_n, lb_n;
    logic [15:0] sram [0:65535];

    int errors = 0, checks = 0;

    mem_responder #(.WAIT_STATES(WS), .MMIO_ADDR(16'hFFFF), .SRAM_AW(20)) dut (
        .Clk(clk), .Reset(rst_n), .Req(req), .WE(we), .Address(address), .Data_In(data_in),
        .Data_Out(data_out), .Ready(ready), .Busy(busy), .Switches(switches), .Hex_Out(hex_out),
        .SRAM_Addr(sram_addr), .SRAM_WData(sram_wdata), .SRAM_RData(sram_rdata),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    always #5 clk = ~clk;

    assign sram_rdata = sram[sram_addr[15:0]];
    always @(posedge clk) if (!ce_n && !we_n) sram[sram_addr[15:0]] <= sram_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request from IDLE; inputs are scrambled after acceptance to prove they were latched
    task automatic run_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                              input logic [15:0] chg, input int hold,
                              output int lat, output int cen, output int oen, output int wen,
                              output logic bus_ok, output logic hold_ok);
        @(negedge clk);
        we = w; address = a; data_in = d; req = 1'b1;
        lat = 0; cen = 0; oen = 0; wen = 0; bus_ok = 1'b1; hold_ok = 1'b1;
        while (!ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            address = chg; data_in = ~d; we = ~w;
            if (!ce_n) cen++;
            if (!oe_n) oen++;
            if (!we_n) wen++;
            if (!ce_n && (sram_addr !== {4'h0, a} || ub_n || lb_n)) bus_ok = 1'b0;
            if (!we_n && sram_wdata !== d) bus_ok = 1'b0;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!(ready && busy) || {ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111) hold_ok = 1'b0;
        end
        @(negedge clk); req = 1'b0;
        @(posedge clk); #1;
        chk("drop_ready", {31'b0, ready}, 0);
        chk("drop_busy", {31'b0, busy}, 0);
    endtask

    typedef struct {
        logic        w;
        logic [15:0] a, d, sw, chg, exp_dout, exp_hex;
    } vec_t;

    vec_t vecs [8];
    logic [15:0] ref_mem [int];
    logic [15:0] ref_dout, ref_hex;

    initial begin
        int lat, cen, oen, wen, exp_lat;
        logic bus_ok, hold_ok, mmio;
        for (int i = 0; i < 65536; i++) sram[i] = '0;
        vecs[0] = '{1'b1, 16'h0040, 16'h1234, 16'h0000, 16'h0041, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 16'h0040, 16'h0000, 16'h0000, 16'hFFFF, 16'h1234, 16'h0000};
        vecs[2] = '{1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 16'h0040, 16'h00A5, 16'h0000};
        vecs[3] = '{1'b1, 16'hFFFF, 16'hBEEF, 16'h1111, 16'h0000, 16'h00A5, 16'hBEEF};
        vecs[4] = '{1'b0, 16'hFFFE, 16'h0000, 16'h2222, 16'hFFFF, 16'h0000, 16'hBEEF};
        vecs[5] = '{1'b1, 16'h0010, 16'h5A5A, 16'h0000, 16'h0020, 16'h0000, 16'hBEEF};
        vecs[6] = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h0020, 16'h5A5A, 16'hBEEF};
        vecs[7] = '{1'b0, 16'h0020, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF};

        #12;
        chk("rst_dout", {16'h0, data_out}, 0);
        chk("rst_hex", {16'h0, hex_out}, 0);
        chk("rst_ready_busy", {30'b0, ready, busy}, 0);
        chk("rst_strobes", {27'b0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
        chk("rst_addr_wdata", {sram_addr[15:0], sram_wdata}, 0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) begin
            switches = vecs[i].sw;
            mmio = (vecs[i].a == 16'hFFFF);
            run_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].chg, 0, lat, cen, oen, wen, bus_ok, hold_ok);
            chk($sformatf("v%0d_lat", i), lat, mmio ? 2 : WS + 1);
            chk($sformatf("v%0d_ce", i), cen, mmio ? 0 : WS);
            chk($sformatf("v%0d_oe", i), oen, (mmio || vecs[i].w) ? 0 : WS);
            chk($sformatf("v%0d_we", i), wen, (mmio || !vecs[i].w) ? 0 : WS);
            chk($sformatf("v%0d_bus", i), {31'b0, bus_ok}, 1);
            chk($sformatf("v%0d_dout", i), {16'h0, data_out}, {16'h0, vecs[i].exp_dout});
            chk($sformatf("v%0d_hex", i), {16'h0, hex_out}, {16'h0, vecs[i].exp_hex});
        end

        run_access(1'b1, 16'h0030, 16'hC0DE, 16'h0031, 10, lat, cen, oen, wen, bus_ok, hold_ok);
        chk("hold_one_access", wen, WS);
        chk("hold_ready_busy", {31'b0, hold_ok}, 1);
        chk("hold_mem", {16'h0, sram[16'h0030]}, 32'hC0DE);

        @(negedge clk); we = 1'b1; address = 16'h0050; data_in = 16'h7777; req = 1'b1;
        @(posedge clk); #3;
        chk("rst_mid_busy_before", {31'b0, busy}, 1);
        rst_n = 1'b0; #1;
        chk("rst_mid_strobes", {27'b0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
        chk("rst_mid_ready_busy", {30'b0, ready, busy}, 0);
        chk("rst_mid_dout_hex", {data_out, hex_out}, 0);
        @(posedge clk); #1;
        chk("rst_mid_req_ignored", {31'b0, busy}, 0);
        chk("rst_mid_no_write", {16'h0, sram[16'h0050]}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_fresh_busy", {31'b0, busy}, 1);
        lat = 1;
        while (!ready && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("rst_fresh_lat", lat, WS + 1);
        chk("rst_fresh_mem", {16'h0, sram[16'h0050]}, 32'h7777);
        @(negedge clk); req = 1'b0;
        @(posedge clk); #1;

        ref_dout = '0; ref_hex = '0;
        for (int n = 0; n < 40; n++) begin
            logic        w;
            logic [15:0] a, d, exp_dout;
            w = 1'($urandom);
            mmio = ($urandom_range(0, 3) == 0);
            a = mmio ? 16'hFFFF : 16'($urandom_range(0, 15));
            d = 16'($urandom);
            switches = 16'($urandom);
            if (mmio && w) ref_hex = d;
            else if (mmio) ref_dout = switches;
            else if (w) ref_mem[int'(a)] = d;
            else ref_dout = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0;
            exp_dout = ref_dout;
            exp_lat = mmio ? 2 : WS + 1;
            run_access(w, a, d, 16'($urandom), 0, lat, cen, oen, wen, bus_ok, hold_ok);
            chk($sformatf("rnd%0d_lat", n), lat, exp_lat);
            chk($sformatf("rnd%0d_dout", n), {16'h0, data_out}, {16'h0, exp_dout});
            chk($sformatf("rnd%0d_hex", n), {16'h0, hex_out}, {16'h0, ref_hex});
            chk($sformatf("rnd%0d_bus", n), {31'b0, bus_ok}, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
